// File: rtl/dmem_lsu_pkg.sv
// Shared types and lane helpers for the data-memory load/store unit.
// Byte-enable masks are for a little-endian 32-bit word.
package dmem_lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_RSV = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RSP  = 2'b11
    } state_e;

    localparam logic [3:0] BE_B = 4'b0001;
    localparam logic [3:0] BE_H = 4'b0011;
    localparam logic [3:0] BE_W = 4'b1111;

    function automatic logic [3:0] be_mask(size_e size, logic [1:0] lane);
        case (size)
            SZ_B:    be_mask = BE_B << lane;
            SZ_H:    be_mask = BE_H << lane;
            SZ_W:    be_mask = BE_W;
            default: be_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic misaligned(size_e size, logic [1:0] lane);
        return ((size == SZ_H) && lane[0]) || ((size == SZ_W) && (lane != 2'b00));
    endfunction

    function automatic logic [1:0] force_align(size_e size, logic [1:0] lane);
        case (size)
            SZ_H:    force_align = {lane[1], 1'b0};
            SZ_W:    force_align = 2'b00;
            default: force_align = lane;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Core-request, response and data-memory port bundle of the load/store unit.
// slave is the LSU view; master is the core + memory view.
interface dmem_lsu_if #(parameter int ADDR_W = 6);

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W+1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_a;
    logic [31:0]       mem_d;
    logic [31:0]       mem_q;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  rsp_ready, mem_q,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_we, mem_a, mem_d
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output rsp_ready, mem_q,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_we, mem_a, mem_d
    );

endinterface

// File: rtl/dmem_lsu_align.sv
// Combinational lane logic: extracts/extends load data from a memory word and
// builds the merged word for sub-word stores.
module dmem_lsu_align
    import dmem_lsu_pkg::*;
(
    input  size_e       size,
    input  logic        sgn,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] old,
    output logic [31:0] ldata,
    output logic [31:0] merged
);

    logic [15:0] shifted;
    logic [31:0] wshift;
    logic [3:0]  be;

    always_comb begin
        shifted = 16'(old >> {lane, 3'b000});
        wshift  = wdata << {lane, 3'b000};
        be      = be_mask(size, lane);
        ldata   = 32'h0;
        merged  = old;
        case (size)
            SZ_B:    ldata = {{24{sgn & shifted[7]}}, shifted[7:0]};
            SZ_H:    ldata = {{16{sgn & shifted[15]}}, shifted[15:0]};
            SZ_W:    ldata = old;
            default: ldata = 32'h0;
        endcase
        for (int i = 0; i < 4; i++) begin
            if (be[i]) merged[8*i +: 8] = wshift[8*i +: 8];
        end
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store initiator between the core memory stage and a word-addressed RAM.
// Build option DMEM_LSU_ALIGN_CHECK_EN: misaligned half/word accesses return an error.
//
// state | meaning
// IDLE  | ready for a request
// RD    | memory word read; load lane extracted or store word merged
// WR    | one-cycle memory write
// RSP   | response held until rsp_ready
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic     clk,
    input  logic     rst,
    dmem_lsu_if.slave bus
);

    state_e            state;
    state_e            state_nxt;
    size_e             size_in;
    size_e             size_q;
    logic [1:0]        lane_in;
    logic [1:0]        lane_q;
    logic              err_in;
    logic              err_q;
    logic              we_q;
    logic              sgn_q;
    logic              accept;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       mem_d_q;
    logic [31:0]       rdata_q;
    logic [31:0]       ldata;
    logic [31:0]       merged;
    logic              req_ready_c;
    logic              rsp_valid_c;
    logic              mem_we_c;

    assign size_in = size_e'(bus.req_size);

`ifdef DMEM_LSU_ALIGN_CHECK_EN
    assign lane_in = bus.req_addr[1:0];
    assign err_in  = (size_in == SZ_RSV) || misaligned(size_in, bus.req_addr[1:0]);
`else
    assign lane_in = force_align(size_in, bus.req_addr[1:0]);
    assign err_in  = (size_in == SZ_RSV);
`endif

    assign accept = bus.req_valid && req_ready_c;

    dmem_lsu_align u_align (
        .size   (size_q),
        .sgn    (sgn_q),
        .lane   (lane_q),
        .wdata  (wdata_q),
        .old    (bus.mem_q),
        .ldata  (ldata),
        .merged (merged)
    );

    always_comb begin
        state_nxt   = state;
        req_ready_c = 1'b0;
        rsp_valid_c = 1'b0;
        mem_we_c    = 1'b0;
        case (state)
            IDLE: begin
                req_ready_c = 1'b1;
                if (bus.req_valid) begin
                    if (err_in)
                        state_nxt = RSP;
                    else if (bus.req_we && (size_in == SZ_W))
                        state_nxt = WR;
                    else
                        state_nxt = RD;
                end
            end
            RD:  state_nxt = we_q ? WR : RSP;
            WR: begin
                mem_we_c  = 1'b1;
                state_nxt = RSP;
            end
            RSP: begin
                rsp_valid_c = 1'b1;
                if (bus.rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            size_q  <= SZ_B;
            lane_q  <= 2'b00;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            sgn_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            mem_d_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                size_q  <= size_in;
                lane_q  <= lane_in;
                sgn_q   <= bus.req_signed;
                we_q    <= bus.req_we;
                wdata_q <= bus.req_wdata;
                err_q   <= err_in;
                rdata_q <= 32'h0;
                // error requests leave the memory port untouched
                if (!err_in) addr_q <= bus.req_addr[ADDR_W+1:2];
                if (!err_in && bus.req_we && (size_in == SZ_W)) mem_d_q <= bus.req_wdata;
            end
            if (state == RD) begin
                if (we_q)
                    mem_d_q <= merged;
                else
                    rdata_q <= ldata;
            end
        end
    end

    // Gate with rst so a reset landing in WR never commits a write.
    assign bus.mem_we    = mem_we_c & rst;
    assign bus.mem_a     = addr_q;
    assign bus.mem_d     = mem_d_q;
    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_c;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: directed requests, a request-level reference model with
// a per-cycle output compare, and literal pins on key results.
`timescale 1ns/1ps
module tb_dmem_lsu;

    localparam int AW = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmem_lsu_if #(.ADDR_W(AW)) bus ();
    dmem_lsu #(.ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];
    int          wr_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    bit          chk_en  = 1'b0;
    bit          busy    = 1'b0;
    int          d       = 0;
    int          e_L     = 1;
    int          first_d = -1;
    bit          e_err   = 1'b0;
    bit          e_wr    = 1'b0;
    logic [31:0] e_rdata = 32'h0;
    logic [31:0] e_md    = 32'h0;
    logic [5:0]  e_a     = 6'h0;
    logic [31:0] last_rdata = 32'h0;
    logic        last_err   = 1'b0;

    function automatic logic [31:0] init_word(int i);
        return {8'hA5, 8'(i), 8'h3C, 8'(255 - i)};
    endfunction

    // memory: combinational read, write on the clock edge
    assign bus.mem_q = mem[bus.mem_a];
    initial begin
        for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
        forever begin
            @(posedge clk);
            if (bus.mem_we === 1'b1) begin
                mem[bus.mem_a] <= bus.mem_d;
                wr_cnt++;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h expected=%08h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
        end
    endtask

    // Request-level model: outcome, latency and memory effect of one access.
    task automatic model_op(input bit we, input logic [1:0] size, input bit sgn,
                            input logic [7:0] addr, input logic [31:0] wdata);
        logic [7:0]  a;
        int          wa;
        int          b;
        int          v;
        logic [31:0] w;
        a     = addr;
        e_err = (size == 2'b11);
`ifdef DMEM_LSU_ALIGN_CHECK_EN
        if (size == 2'b01 && a[0]) e_err = 1'b1;
        if (size == 2'b10 && a[1:0] != 2'b00) e_err = 1'b1;
`else
        if (size == 2'b01) a[0] = 1'b0;
        if (size == 2'b10) a[1:0] = 2'b00;
`endif
        wa      = int'(a[7:2]);
        b       = int'(a[1:0]);
        w       = ref_mem[wa];
        e_a     = a[7:2];
        e_rdata = 32'h0;
        e_wr    = 1'b0;
        e_md    = 32'h0;
        if (e_err) begin
            e_L = 1;
        end else if (!we) begin
            e_L = 2;
            if (size == 2'b00) begin
                v = int'((w >> (8 * b)) % 256);
                if (sgn && v >= 128) v = v - 256;
            end else if (size == 2'b01) begin
                v = int'((w >> (8 * b)) % 65536);
                if (sgn && v >= 32768) v = v - 65536;
            end else begin
                v = int'(w);
            end
            e_rdata = 32'(v);
        end else begin
            e_wr = 1'b1;
            e_L  = (size == 2'b10) ? 2 : 3;
            if (size == 2'b00)      ref_mem[wa][8*b +: 8]  = wdata[7:0];
            else if (size == 2'b01) ref_mem[wa][8*b +: 16] = wdata[15:0];
            else                    ref_mem[wa]            = wdata;
            e_md = ref_mem[wa];
        end
    endtask

    // per-cycle compare against the model's expectations
    always @(negedge clk) begin : cmp
        bit ev;
        bit ew;
        if (chk_en) begin
            ev = busy && (d >= e_L - 1);
            ew = busy && e_wr && (d == e_L - 2);
            chk1("req_ready", bus.req_ready, !busy);
            chk1("rsp_valid", bus.rsp_valid, ev);
            chk1("mem_we", bus.mem_we, ew);
            if (ev) begin
                chk("rsp_rdata", bus.rsp_rdata, e_rdata);
                chk1("rsp_err", bus.rsp_err, e_err);
                if (first_d < 0) first_d = d;
                last_rdata = bus.rsp_rdata;
                last_err   = bus.rsp_err;
            end
            if (busy && !e_err && (d <= e_L - 2)) chk("mem_a", 32'(bus.mem_a), 32'(e_a));
            if (ew) chk("mem_d", bus.mem_d, e_md);
        end
    end

    // Called at posedge+1; returns at posedge+1 of the first idle cycle.
    task automatic do_req(input bit we, input logic [1:0] size, input bit sgn,
                          input logic [7:0] addr, input logic [31:0] wdata,
                          input int stall, input bit pulse);
        int wc0;
        bit done;
        wc0 = wr_cnt;
        model_op(we, size, sgn, addr, wdata);
        bus.req_we     = we;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_valid  = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        busy    = 1'b1;
        d       = 0;
        first_d = -1;
        if (pulse) begin
            bus.req_we    = 1'b1;
            bus.req_size  = 2'b10;
            bus.req_addr  = addr;
            bus.req_wdata = 32'hFFFF_FFFF;
        end
        done = 1'b0;
        for (int k = 0; k < 64 && !done; k++) begin
            bus.rsp_ready = (d >= e_L - 1) && (d - (e_L - 1) >= stall);
            bus.req_valid = pulse && (d == e_L);
            @(posedge clk); #1;
            if (bus.rsp_ready) begin
                done          = 1'b1;
                bus.rsp_ready = 1'b0;
                bus.req_valid = 1'b0;
                busy          = 1'b0;
            end else begin
                d++;
            end
        end
        if (!done) begin
            chk1("rsp_timeout", 1'b0, 1'b1);
            busy          = 1'b0;
            bus.rsp_ready = 1'b0;
            bus.req_valid = 1'b0;
        end
        chk("write_count", 32'(wr_cnt - wc0), e_wr ? 32'd1 : 32'd0);
        chk("mem_word", mem[addr[7:2]], ref_mem[addr[7:2]]);
    endtask

    task automatic chk_reset_vals();
        chk1("rst_req_ready", bus.req_ready, 1'b1);
        chk1("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk1("rst_rsp_err", bus.rsp_err, 1'b0);
        chk1("rst_mem_we", bus.mem_we, 1'b0);
        chk("rst_mem_a", 32'(bus.mem_a), 32'h0);
        chk("rst_mem_d", bus.mem_d, 32'h0);
    endtask

    task automatic rst_mid_store();
        int wc0;
        chk_en = 1'b0;
        wc0    = wr_cnt;
        bus.req_we     = 1'b1;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = 8'h21;
        bus.req_wdata  = 32'h0000_0055;
        bus.req_valid  = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk1("rdrst_mem_we", bus.mem_we, 1'b0);
        chk("rdrst_mem_a", 32'(bus.mem_a), 32'h8);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals();
        @(posedge clk); #1;
        chk("rdrst_wcnt", 32'(wr_cnt - wc0), 32'h0);
        chk("rdrst_mem8", mem[8], 32'h80FF_7F01);
        chk("rdrst_ref8", mem[8], ref_mem[8]);
        busy   = 1'b0;
        chk_en = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = 8'h00;
        bus.req_wdata  = 32'h0;
        bus.rsp_ready  = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals();
        @(posedge clk); #1;
        rst    = 1'b1;
        chk_en = 1'b1;

        do_req(1'b1, 2'b10, 1'b0, 8'h10, 32'hDEAD_BEEF, 0, 1'b0);
        chk("wst_mem4", mem[4], 32'hDEAD_BEEF);
        chk("wst_lat", 32'(first_d + 1), 32'd2);
        do_req(1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 0, 1'b0);
        chk("wld_data", last_rdata, 32'hDEAD_BEEF);
        chk("wld_lat", 32'(first_d + 1), 32'd2);

        do_req(1'b1, 2'b10, 1'b0, 8'h10, 32'h1122_3344, 0, 1'b0);
        do_req(1'b1, 2'b00, 1'b0, 8'h12, 32'h0000_00AA, 0, 1'b0);
        chk("bst_mem4", mem[4], 32'h11AA_3344);
        chk("bst_lat", 32'(first_d + 1), 32'd3);

        do_req(1'b1, 2'b10, 1'b0, 8'h20, 32'h80FF_7F01, 0, 1'b0);
        do_req(1'b0, 2'b00, 1'b1, 8'h23, 32'h0, 0, 1'b0);
        chk("ldb_s", last_rdata, 32'hFFFF_FF80);
        do_req(1'b0, 2'b00, 1'b0, 8'h23, 32'h0, 0, 1'b0);
        chk("ldb_u", last_rdata, 32'h0000_0080);
        do_req(1'b0, 2'b01, 1'b1, 8'h20, 32'h0, 0, 1'b0);
        chk("ldh_s0", last_rdata, 32'h0000_7F01);
        do_req(1'b0, 2'b01, 1'b1, 8'h22, 32'h0, 0, 1'b0);
        chk("ldh_s2", last_rdata, 32'hFFFF_80FF);

        do_req(1'b0, 2'b01, 1'b0, 8'h13, 32'h0, 0, 1'b0);
`ifdef DMEM_LSU_ALIGN_CHECK_EN
        chk1("mis_h_err", last_err, 1'b1);
        chk("mis_h_data", last_rdata, 32'h0);
        chk("mis_h_lat", 32'(first_d + 1), 32'd1);
`else
        chk1("mis_h_err", last_err, 1'b0);
        chk("mis_h_data", last_rdata, 32'h0000_11AA);
        chk("mis_h_lat", 32'(first_d + 1), 32'd2);
`endif

        do_req(1'b0, 2'b11, 1'b0, 8'h14, 32'h0, 0, 1'b0);
        chk1("rsv_ld_err", last_err, 1'b1);
        chk("rsv_ld_lat", 32'(first_d + 1), 32'd1);
        do_req(1'b1, 2'b11, 1'b0, 8'h14, 32'h1234_5678, 0, 1'b0);
        chk1("rsv_st_err", last_err, 1'b1);

        do_req(1'b1, 2'b01, 1'b0, 8'h16, 32'h0000_BEEF, 0, 1'b0);
        do_req(1'b0, 2'b10, 1'b0, 8'h14, 32'h0, 5, 1'b1);
        chk("stall_data", last_rdata, 32'hBEEF_3CFA);
        chk("stall_mem5", mem[5], 32'hBEEF_3CFA);

        do_req(1'b1, 2'b10, 1'b0, 8'h1B, 32'hCAFE_F00D, 0, 1'b0);
        do_req(1'b0, 2'b10, 1'b0, 8'h18, 32'h0, 2, 1'b0);
        do_req(1'b0, 2'b00, 1'b1, 8'h19, 32'h0, 0, 1'b0);
        do_req(1'b1, 2'b01, 1'b0, 8'h1A, 32'h0000_1357, 1, 1'b0);
        do_req(1'b0, 2'b01, 1'b1, 8'h1A, 32'h0, 0, 1'b0);
        chk("ldh_1a", last_rdata, 32'h0000_1357);

        rst_mid_store();
        do_req(1'b0, 2'b10, 1'b0, 8'h20, 32'h0, 0, 1'b0);
        chk("post_rst_ld", last_rdata, 32'h80FF_7F01);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
